// File: rtl/topology_link_fabric.sv
// Registered mesh / torus / circulant link fabric between router ports.
// Every connected directed link is a small valid/ready FIFO; unconnected ports flag stray valids.
module topology_link_fabric #(
  parameter int unsigned PORT_SIZE  = 39,
  parameter int unsigned PORTS_NUM  = 4,
  parameter int unsigned NODES_NUM  = 4,
  parameter int unsigned TOPOLOGY   = 0,
  parameter int unsigned H_SIZE     = 2,
  parameter int unsigned S0         = 1,
  parameter int unsigned S1         = 2,
  parameter int unsigned LINK_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NODES_NUM*PORTS_NUM*PORT_SIZE-1:0] data_i,
  output logic [NODES_NUM*PORTS_NUM*PORT_SIZE-1:0] data_o,
  output logic [NODES_NUM*PORTS_NUM-1:0]           edge_err
);

  localparam int unsigned Slices = NODES_NUM * PORTS_NUM;
  localparam int unsigned PW     = PORT_SIZE - 2;
  localparam int unsigned AW     = $clog2(LINK_DEPTH);
  localparam int unsigned CntW   = AW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(LINK_DEPTH);

  if (PORTS_NUM != 4) begin : g_bad_ports
    $error("PORTS_NUM must be 4");
  end
  if (TOPOLOGY > 2) begin : g_bad_topo
    $error("TOPOLOGY must be 0, 1 or 2");
  end
  if (H_SIZE == 0 || (NODES_NUM % H_SIZE) != 0) begin : g_bad_h
    $error("NODES_NUM must be a multiple of H_SIZE");
  end
  if (TOPOLOGY == 2 && (S0 == 0 || S0 >= NODES_NUM || S1 == 0 || S1 >= NODES_NUM)) begin : g_bad_s
    $error("circulant steps must lie in 1..NODES_NUM-1");
  end
  if (LINK_DEPTH < 2 || (LINK_DEPTH & (LINK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("LINK_DEPTH must be a power of 2, at least 2");
  end

  // Node reached through port p of node n, or -1 when the port leaves the grid.
  function automatic int neighbour(int n, int p);
    int nodes = int'(NODES_NUM);
    int h     = int'(H_SIZE);
    int rows  = nodes / h;
    int nx    = n % h;
    int ny    = n / h;
    if (TOPOLOGY == 2) begin
      case (p)
        0:       return (n + int'(S0)) % nodes;
        1:       return (n + nodes - int'(S0)) % nodes;
        2:       return (n + int'(S1)) % nodes;
        default: return (n + nodes - int'(S1)) % nodes;
      endcase
    end
    case (p)
      0:       nx = nx + 1;
      1:       nx = nx - 1;
      2:       ny = ny - 1;
      default: ny = ny + 1;
    endcase
    if (TOPOLOGY == 1) begin
      nx = (nx + h) % h;
      ny = (ny + rows) % rows;
    end else if (nx < 0 || nx >= h || ny < 0 || ny >= rows) begin
      return -1;
    end
    return ny * h + nx;
  endfunction

  logic [Slices-1:0] lnk_valid;
  logic [Slices-1:0] lnk_full;
  logic [PW-1:0]     lnk_head [Slices];

  for (genvar i = 0; i < int'(Slices); i++) begin : g_slice
    localparam int          Node = i / int'(PORTS_NUM);
    localparam int          Port = i % int'(PORTS_NUM);
    localparam int          Peer = neighbour(Node, Port);
    localparam int unsigned Base = i * PORT_SIZE;

    if (Peer >= 0) begin : g_link
      // The opposite port of the peer is both where this link lands and where the
      // incoming link for this port originates, since every mapping is symmetric.
      localparam int unsigned PeerIdx  = int'(Peer) * int'(PORTS_NUM) + (Port ^ 1);
      localparam int unsigned PeerBase = PeerIdx * PORT_SIZE;

      logic [PW-1:0]   mem_q [LINK_DEPTH];
      logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
      logic [CntW-1:0] cnt_q, cnt_d;
      logic            push, pop;

      assign lnk_full[i]  = (cnt_q == FullCnt);
      assign lnk_valid[i] = (cnt_q != '0);
      assign lnk_head[i]  = lnk_valid[i] ? mem_q[rd_ptr_q] : '0;

      assign push = data_i[Base + PORT_SIZE - 2] && !lnk_full[i];
      assign pop  = lnk_valid[i] && data_i[PeerBase + PORT_SIZE - 1];

      always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
          cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
          cnt_q <= cnt_d;
        end
      end

      // Storage needs no reset: the head is masked whenever the FIFO is empty.
      always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i[Base +: PW];
      end

      assign data_o[Base +: PORT_SIZE] = {~lnk_full[i], lnk_valid[PeerIdx], lnk_head[PeerIdx]};
      assign edge_err[i] = 1'b0;
    end else begin : g_edge
      logic err_q;
      logic unused_in;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          err_q <= 1'b0;
        end else if (data_i[Base + PORT_SIZE - 2]) begin
          err_q <= 1'b1;
        end
      end

      assign lnk_valid[i] = 1'b0;
      assign lnk_full[i]  = 1'b0;
      assign lnk_head[i]  = '0;
      assign unused_in = ^{data_i[Base + PORT_SIZE - 1], data_i[Base +: PW],
                           lnk_valid[i], lnk_full[i], lnk_head[i]};

      assign data_o[Base +: PORT_SIZE] = '0;
      assign edge_err[i] = err_q;
    end
  end

endmodule

// File: doc/topology_link_fabric.md
# topology_link_fabric

Registered, flow-controlled successor to the compile-time topology connector. It links the router ports of NODES_NUM nodes as a 2D mesh, 2D torus or 2-step circulant, with the topology chosen by parameter instead of macro. Every directed link carries a LINK_DEPTH-entry FIFO with valid/ready backpressure. The block sits between the router array and the rest of the NoC and replaces the purely combinational connector.

## Interface
- PORT_SIZE, 39: bits per port slice; [PORT_SIZE-3:0] payload, [PORT_SIZE-2] valid, [PORT_SIZE-1] ready
- PORTS_NUM, 4: ports per node; fixed at 4, any other value is an elaboration error
- NODES_NUM, 4: node count
- TOPOLOGY, 0: 0 = mesh_2d, 1 = torus, 2 = circulant_2; other values are an elaboration error
- H_SIZE, 2: row width for mesh/torus; NODES_NUM % H_SIZE must be 0
- S0, 1 and S1, 2: circulant steps, 0 < S < NODES_NUM
- LINK_DEPTH, 2: FIFO entries per link; power of 2, ≥ 2
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_i  in  NODES_NUM*PORTS_NUM*PORT_SIZE  per node/port (slice index n*PORTS_NUM+p):
  - outgoing payload and valid
  - ready, meaning the node port can accept an incoming flit
- data_o  out  NODES_NUM*PORTS_NUM*PORT_SIZE  per node/port:
  - incoming payload and valid
  - ready, meaning the outgoing link can accept a flit
- edge_err  out  NODES_NUM*PORTS_NUM  sticky: valid was seen on an unconnected port

## Operation
- Node n is at x = n % H_SIZE, y = n / H_SIZE.
- Mesh/torus port mapping:
  - port 0 → x+1, port 1 → x-1, port 2 → y-1, port 3 → y+1
  - the destination port is the opposite port (0↔1, 2↔3)
- Torus wraps x modulo H_SIZE and y modulo NODES_NUM/H_SIZE.
- Mesh edge ports that would leave the grid are unconnected.
- Circulant port mapping, all modulo NODES_NUM:
  - port 0 → n+S0, port 1 → n−S0, port 2 → n+S1, port 3 → n−S1
  - the destination port is the opposite port
- Each connected directed link (src n,p → dst m,q) has its own FIFO:
  - push when src valid && data_o[n,p].ready
  - data_o[n,p].ready = !full
  - data_o[m,q].valid = !empty, and its payload is the FIFO head
  - pop when data_o[m,q].valid && data_i[m,q].ready
- Unconnected port:
  - data_o ready = 0, valid = 0, payload = 0
  - any valid on data_i sets the matching edge_err bit, which stays set until reset
  - the flit is discarded
- The incoming ready bit of data_i on the source side is ignored.
- The outgoing valid/payload of data_i on the destination side only drives its own outgoing link.
- Push and pop in the same cycle are allowed when not full and not empty; occupancy is unchanged and order is preserved.
- Pointers wrap modulo LINK_DEPTH. Occupancy counter width is clog2(LINK_DEPTH)+1.
- No flit is dropped, duplicated or reordered on a connected link.

## Timing
- Reset (rst_n low, asynchronous), for all links:
  - FIFOs empty
  - data_o valid = 0, payload = 0
  - ready = 1 on connected ports, 0 on unconnected ports
  - edge_err = 0
- Reset asserted mid-transfer flushes all in-flight flits with no partial state.
- The first edge after rst_n rises can accept a push.
- Latency: a flit pushed at edge k is visible on data_o at the destination after edge k, i.e. in cycle k+1. There is no same-cycle bypass.
- Throughput is 1 flit/cycle/link while the receiver holds ready.
- When full, ready drops in the cycle after the filling push. A pop in a full cycle frees space, but ready stays 0 in that cycle because ready = !full is registered-state based, not combinational on pop.
- Holding valid with ready low retains the flit at the source; the sender must keep payload stable.
- edge_err sets at the edge where an unconnected valid is sampled.

## Test plan
- Mesh, NODES_NUM=4, H_SIZE=2:
  - node0 port0 sends 0x1234 → node1 port1 valid with 0x1234 one cycle later
  - node0 port1 valid → edge_err[1] = 1 and no output anywhere
- Torus, NODES_NUM=4, H_SIZE=2: node1 port0 sends 0xA → node0 port1 receives 0xA (x wrap). node0 port2 sends 0xB → node2 port3 receives 0xB (y wrap).
- Circulant, NODES_NUM=5, S0=1, S1=2: node4 port2 sends 0x7 → node1 port3 receives 0x7.
- Backpressure, LINK_DEPTH=2:
  - destination ready=0 and source streams 1, 2, 3 → ready drops after 2 pushes and flit 3 is held
  - releasing ready delivers 1, 2, 3 in order, one per cycle
- Streaming: 100 back-to-back flits with the receiver always ready → 100 flits received in 100 consecutive cycles, count and order exact.
- Reset mid-operation: with 2 flits queued, pulse rst_n low asynchronously → valid = 0 immediately, ready = 1, edge_err cleared, and no stale flit after release.
